// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the RV32M iterative mul/div unit.
// Holds the funct3 opcode enum, FSM state enum and special result values.
package muldiv_pkg;

  localparam int XLEN  = 32;
  localparam int ITERS = 32;

  localparam logic [XLEN-1:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] INT_MIN   = 32'h8000_0000;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } muldiv_state_e;

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: request/response bundle between the issue stage and muldiv_unit.
// master drives the request, slave (the unit) drives status and result.
interface muldiv_if;
  import muldiv_pkg::*;

  logic            start;
  logic            flush;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [4:0]      rd_in;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;
  logic            rfwrite_out;

  modport master (
    output start, flush, funct3,
    output op_a, op_b, rd_in,
    input  busy, done, result,
    input  rd_out, rfwrite_out
  );

  modport slave (
    input  start, flush, funct3,
    input  op_a, op_b, rd_in,
    output busy, done, result,
    output rd_out, rfwrite_out
  );

endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide (shift-add, restoring divide).
// Define MULDIV_FAST_PATH_EN to let trivial cases skip CALC/FIX.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);

  localparam int CW = $clog2(ITERS) + 1;

  muldiv_state_e     r_state;
  muldiv_state_e     w_next;
  muldiv_op_e        r_op;
  muldiv_op_e        w_op;
  logic [4:0]        r_rd;
  logic [4:0]        r_rd_out;
  logic [XLEN-1:0]   r_mc;
  logic [XLEN-1:0]   r_result;
  logic [2*XLEN-1:0] r_acc;
  logic [CW-1:0]     r_cnt;
  logic              r_neg_q;
  logic              r_neg_r;
  logic              r_div0;
  logic              r_is_div;

  logic              w_accept;
  logic              w_sa;
  logic              w_sb;
  logic              w_neg_a;
  logic              w_neg_b;
  logic [XLEN-1:0]   w_abs_a;
  logic [XLEN-1:0]   w_abs_b;
  logic [XLEN:0]     w_madd;
  logic [XLEN:0]     w_shift;
  logic              w_ge;
  logic [XLEN-1:0]   w_sub;
  logic [2*XLEN-1:0] w_step;

  function automatic logic [XLEN-1:0] fix_result(
    input muldiv_op_e        op,
    input logic [2*XLEN-1:0] acc,
    input logic              neg_q,
    input logic              neg_r,
    input logic              div0
  );
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   res;
    prod = neg_q ? -acc : acc;
    quo  = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    res  = prod[XLEN-1:0];
    unique case (op)
      OP_MUL:    res = prod[XLEN-1:0];
      OP_MULH,
      OP_MULHSU,
      OP_MULHU:  res = prod[2*XLEN-1:XLEN];
      OP_DIV,
      OP_DIVU:   res = div0 ? DIV0_QUOT : quo;
      OP_REM,
      OP_REMU:   res = rem;
      default:   res = prod[XLEN-1:0];
    endcase
    return res;
  endfunction

  always_comb begin
    w_op     = muldiv_op_e'(bus.funct3);
    w_accept = (r_state == S_IDLE) && bus.start && !bus.flush;
    w_sa     = !(w_op == OP_MULHU || w_op == OP_DIVU ||
                 w_op == OP_REMU);
    w_sb     = (w_op == OP_MUL || w_op == OP_MULH ||
                w_op == OP_DIV || w_op == OP_REM);
    w_neg_a  = w_sa && bus.op_a[XLEN-1];
    w_neg_b  = w_sb && bus.op_b[XLEN-1];
    w_abs_a  = w_neg_a ? -bus.op_a : bus.op_a;
    w_abs_b  = w_neg_b ? -bus.op_b : bus.op_b;
  end

  // mul: acc = {partial, multiplier}; div: acc = {remainder, dividend/quotient}
  always_comb begin
    w_madd  = {1'b0, r_acc[2*XLEN-1:XLEN]} +
              (r_acc[0] ? {1'b0, r_mc} : '0);
    w_shift = r_acc[2*XLEN-1:XLEN-1];
    w_ge    = w_shift >= {1'b0, r_mc};
    w_sub   = w_shift[XLEN-1:0] - r_mc;
    w_step  = {w_madd, r_acc[XLEN-1:1]};
    if (r_is_div) begin
      if (w_ge)
        w_step = {w_sub, r_acc[XLEN-2:0], 1'b1};
      else
        w_step = {r_acc[2*XLEN-2:0], 1'b0};
    end
  end

`ifdef MULDIV_FAST_PATH_EN
  logic            w_fast;
  logic [XLEN-1:0] w_fast_val;
  logic            w_b0;
  logic            w_ovf;

  always_comb begin
    w_fast     = 1'b0;
    w_fast_val = '0;
    w_b0       = (bus.op_b == '0);
    w_ovf      = (bus.op_a == INT_MIN) && (bus.op_b == '1);
    unique case (w_op)
      OP_MUL, OP_MULH,
      OP_MULHSU, OP_MULHU: begin
        w_fast     = (bus.op_a == '0) || w_b0;
        w_fast_val = '0;
      end
      OP_DIV, OP_REM: begin
        w_fast     = w_b0 || w_ovf;
        w_fast_val = w_b0 ? ((w_op == OP_DIV) ? DIV0_QUOT : bus.op_a)
                          : ((w_op == OP_DIV) ? INT_MIN : '0);
      end
      OP_DIVU, OP_REMU: begin
        w_fast     = w_b0;
        w_fast_val = (w_op == OP_DIVU) ? DIV0_QUOT : bus.op_a;
      end
      default: begin
        w_fast     = 1'b0;
        w_fast_val = '0;
      end
    endcase
  end
`endif

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
`ifdef MULDIV_FAST_PATH_EN
          w_next = w_fast ? S_DONE : S_CALC;
`else
          w_next = S_CALC;
`endif
        end
      end
      S_CALC: if (r_cnt == CW'(ITERS - 1)) w_next = S_FIX;
      S_FIX:  w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (bus.flush) w_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_op     <= OP_MUL;
      r_rd     <= '0;
      r_rd_out <= '0;
      r_mc     <= '0;
      r_result <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_is_div <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op     <= w_op;
        r_rd     <= bus.rd_in;
        r_neg_q  <= w_neg_a ^ w_neg_b;
        r_neg_r  <= w_neg_a;
        r_div0   <= (bus.op_b == '0);
        r_is_div <= bus.funct3[2];
        r_cnt    <= '0;
        r_acc    <= {{XLEN{1'b0}},
                     bus.funct3[2] ? w_abs_a : w_abs_b};
        r_mc     <= bus.funct3[2] ? w_abs_b : w_abs_a;
`ifdef MULDIV_FAST_PATH_EN
        if (w_fast) begin
          r_result <= w_fast_val;
          r_rd_out <= bus.rd_in;
        end
`endif
      end
      if (r_state == S_CALC && !bus.flush) begin
        r_acc <= w_step;
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_state == S_FIX && !bus.flush) begin
        r_result <= fix_result(r_op, r_acc, r_neg_q,
                               r_neg_r, r_div0);
        r_rd_out <= r_rd;
      end
    end
  end

  assign bus.busy        = (r_state != S_IDLE);
  assign bus.done        = (r_state == S_DONE);
  assign bus.rfwrite_out = (r_state == S_DONE);
  assign bus.result      = r_result;
  assign bus.rd_out      = r_rd_out;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed checks of muldiv_unit results, latency and control.
// Special-case latency follows MULDIV_FAST_PATH_EN when it is defined.
module tb_muldiv_unit;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   k;
  int   c;

  localparam int LAT_FULL = 33;
`ifdef MULDIV_FAST_PATH_EN
  localparam int LAT_SP = 0;
`else
  localparam int LAT_SP = 33;
`endif

  muldiv_if bus ();

  muldiv_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd);
    bus.funct3 = f;
    bus.op_a   = a;
    bus.op_b   = b;
    bus.rd_in  = rd;
    bus.start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start  = 1'b0;
    bus.op_a   = ~a;
    bus.op_b   = ~b;
    bus.rd_in  = ~rd;
  endtask

  task automatic wait_done(inout int kk);
    while (!bus.done && kk < 60) begin
      @(negedge clk);
      kk++;
    end
  endtask

  task automatic count_done(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.done) cnt++;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp,
                        input int lat);
    int kk;
    issue(f, a, b, rd);
    kk = 0;
    chk({tag, "_busy"}, {31'b0, bus.busy}, 32'd1);
    wait_done(kk);
    chk({tag, "_lat"}, kk, lat);
    chk({tag, "_res"}, bus.result, exp);
    chk({tag, "_rd"}, {27'b0, bus.rd_out}, {27'b0, rd});
    chk({tag, "_wr"}, {31'b0, bus.rfwrite_out}, 32'd1);
    @(negedge clk);
    chk({tag, "_pulse"}, {31'b0, bus.done}, 32'd0);
    chk({tag, "_idle"}, {31'b0, bus.busy}, 32'd0);
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.flush  = 1'b0;
    bus.funct3 = 3'b000;
    bus.op_a   = '0;
    bus.op_b   = '0;
    bus.rd_in  = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_done", {31'b0, bus.done}, 32'd0);
    chk("rst_res", bus.result, 32'd0);
    chk("rst_rd", {27'b0, bus.rd_out}, 32'd0);
    chk("rst_wr", {31'b0, bus.rfwrite_out}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("mul", 3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5,
           32'hFFFF_FFEB, LAT_FULL);
    run_op("mulh", 3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6,
           32'h4000_0000, LAT_FULL);
    run_op("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,
           32'hFFFF_FFFE, LAT_FULL);
    run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'd2, 5'd8,
           32'hFFFF_FFFF, LAT_FULL);
    run_op("mul0", 3'b000, 32'd0, 32'h1234_5678, 5'd9,
           32'd0, LAT_SP);
    run_op("div", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd10,
           32'hFFFF_FFFD, LAT_FULL);
    run_op("rem", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd11,
           32'hFFFF_FFFF, LAT_FULL);
    run_op("divu", 3'b101, 32'd100, 32'd7, 5'd12, 32'd14, LAT_FULL);
    run_op("remu", 3'b111, 32'd100, 32'd7, 5'd13, 32'd2, LAT_FULL);
    run_op("div0", 3'b100, 32'd5, 32'd0, 5'd14,
           32'hFFFF_FFFF, LAT_SP);
    run_op("rem0", 3'b110, 32'd5, 32'd0, 5'd15, 32'd5, LAT_SP);
    run_op("remneg0", 3'b110, 32'hFFFF_FFFB, 32'd0, 5'd16,
           32'hFFFF_FFFB, LAT_SP);
    run_op("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17,
           32'h8000_0000, LAT_SP);
    run_op("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18,
           32'd0, LAT_SP);
    run_op("remu_pre", 3'b111, 32'd100, 32'd7, 5'd19, 32'd2, LAT_FULL);

    // flush at iteration 10 of a DIV: nothing written, old result kept
    issue(3'b100, 32'd1000, 32'd3, 5'd20);
    repeat (10) @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush_busy", {31'b0, bus.busy}, 32'd0);
    chk("flush_done", {31'b0, bus.done}, 32'd0);
    chk("flush_res", bus.result, 32'd2);
    chk("flush_rd", {27'b0, bus.rd_out}, 32'd19);
    count_done(40, c);
    chk("flush_nodone", c, 32'd0);

    // start while busy is ignored
    issue(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd21);
    k = 0;
    repeat (5) begin
      @(negedge clk);
      k++;
    end
    bus.funct3 = 3'b101;
    bus.op_a   = 32'd100;
    bus.op_b   = 32'd7;
    bus.rd_in  = 5'd22;
    bus.start  = 1'b1;
    @(negedge clk);
    k++;
    bus.start  = 1'b0;
    wait_done(k);
    chk("busy_start_lat", k, LAT_FULL);
    chk("busy_start_res", bus.result, 32'hFFFF_FFEB);
    chk("busy_start_rd", {27'b0, bus.rd_out}, 32'd21);
    count_done(40, c);
    chk("busy_start_single", c, 32'd0);

    // start and flush together in IDLE: not accepted
    bus.funct3 = 3'b101;
    bus.op_a   = 32'd50;
    bus.op_b   = 32'd5;
    bus.start  = 1'b1;
    bus.flush  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start  = 1'b0;
    bus.flush  = 1'b0;
    chk("sf_busy", {31'b0, bus.busy}, 32'd0);
    count_done(40, c);
    chk("sf_nodone", c, 32'd0);
    chk("sf_res", bus.result, 32'hFFFF_FFEB);

    // synchronous reset mid-CALC
    issue(3'b101, 32'd100, 32'd7, 5'd23);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mrst_busy", {31'b0, bus.busy}, 32'd0);
    chk("mrst_done", {31'b0, bus.done}, 32'd0);
    chk("mrst_res", bus.result, 32'd0);
    chk("mrst_rd", {27'b0, bus.rd_out}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // back-to-back: second start lands in the IDLE cycle after DONE
    run_op("b2b_mul", 3'b000, 32'd7, 32'hFFFF_FFFD, 5'd24,
           32'hFFFF_FFEB, LAT_FULL);
    run_op("b2b_divu", 3'b101, 32'd100, 32'd7, 5'd25,
           32'd14, LAT_FULL);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
